// File: rtl/conv_post_pkg.sv
// conv_post_pkg: shared widths, parameter defaults and the requantisation helper
// for the convolution post-processing stage.
package conv_post_pkg;
    localparam int WEIGHT_SIZE = 4;
    localparam int DATA_W      = 32;
    localparam int OUT_W_DEF   = 16;
    localparam int SHIFT_DEF   = 8;

    // ReLU, arithmetic shift, then clamp to the largest positive OUT_W value.
    function automatic logic [DATA_W-1:0] requant(input logic [DATA_W-1:0] s, input int shift,
                                                 input int out_w);
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] lim;
        q   = s[DATA_W-1] ? '0 : s >> shift;
        lim = (DATA_W'(1) << (out_w - 1)) - DATA_W'(1);
        return (q > lim) ? lim : q;
    endfunction
endpackage

// File: rtl/conv_post_if.sv
// conv_post_if: conv-array result bus, bias and valid/ready output stream of conv_post.
interface conv_post_if import conv_post_pkg::*; #(
    parameter int LANES = WEIGHT_SIZE,
    parameter int OUT_W = OUT_W_DEF
);
    logic [LANES-1:0][DATA_W-1:0] conv_data;
    logic [LANES-1:0]             conv_valid;
    logic                         conv_stall;
    logic [LANES-1:0][DATA_W-1:0] bias;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0][OUT_W-1:0]  out_data;

    modport master (
        output conv_data, conv_valid, bias, out_ready,
        input  conv_stall, out_valid, out_data
    );
    modport slave (
        input  conv_data, conv_valid, bias, out_ready,
        output conv_stall, out_valid, out_data
    );
endinterface

// File: rtl/conv_post_fifo.sv
// conv_post_fifo: show-ahead synchronous FIFO with occupancy count; a write to a full
// FIFO is accepted only when a read happens in the same cycle.
module conv_post_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_rd,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_we;
    logic          w_re;

    assign o_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_re    = i_rd && !o_empty;
    assign w_we    = i_wr && (!w_full || w_re);
    assign o_count = r_cnt;
    assign o_rdata = o_empty ? '0 : r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wp] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_we) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (w_re) r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_we) - CW'(w_re);
        end
    end
endmodule

// File: rtl/conv_post.sv
// conv_post: realigns the systolic array's lane-staggered results, applies bias, ReLU,
// shift requantisation and saturation, and buffers vectors behind a valid/ready output.
module conv_post import conv_post_pkg::*; #(
    parameter int LANES      = WEIGHT_SIZE,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = 2 * LANES
) (
    input logic        clk,
    input logic        rst,
    conv_post_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                         w_adv;
    logic                         w_al_vld;
    logic [LANES-1:0][DATA_W-1:0] w_al_data;
    logic [LANES-1:0][OUT_W-1:0]  w_q;
    logic [LANES-1:0][OUT_W-1:0]  r_post;
    logic                         r_post_vld;
    logic                         w_wr;
    logic                         w_rd;
    logic                         w_empty;
    logic [CW-1:0]                w_count;
    logic [LANES*OUT_W-1:0]       w_head;

    // Same freeze condition as the array itself, so lane skew is preserved across stalls.
    assign w_adv = !(bus.conv_stall && |bus.conv_valid);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int D = LANES - 1 - j;
        logic [DATA_W-1:0] w_sum;
        if (D == 0) begin : g_direct
            assign w_al_data[j] = bus.conv_data[j];
        end else begin : g_dly
            logic [DATA_W-1:0] r_d [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) r_d[k] <= '0;
                end else if (w_adv) begin
                    r_d[0] <= bus.conv_data[j];
                    for (int k = 1; k < D; k++) r_d[k] <= r_d[k-1];
                end
            end
            assign w_al_data[j] = r_d[D-1];
        end
        assign w_sum  = w_al_data[j] + bus.bias[j];
        assign w_q[j] = OUT_W'(requant(w_sum, SHIFT, OUT_W));
    end

    // Only lane 0 carries the vector's valid; the other lanes' valids are implied by skew.
    if (LANES > 1) begin : g_vpipe
        logic [LANES-2:0] r_v;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_v <= '0;
            else if (w_adv) r_v <= (LANES-1)'({r_v, bus.conv_valid[0]});
        end
        assign w_al_vld = r_v[LANES-2];
    end else begin : g_vdirect
        assign w_al_vld = bus.conv_valid[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_post     <= '0;
            r_post_vld <= 1'b0;
        end else if (w_adv) begin
            r_post     <= w_q;
            r_post_vld <= w_al_vld;
        end
    end

    assign w_wr = w_adv && r_post_vld;
    assign w_rd = bus.out_valid && bus.out_ready;

    conv_post_fifo #(.W(LANES * OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr),
        .i_wdata (r_post),
        .i_rd    (w_rd),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Headroom of LANES entries absorbs what is still in the deskew/post pipeline.
    assign bus.conv_stall = (w_count >= CW'(FIFO_DEPTH - LANES));
    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_head;
endmodule

// File: tb/tb_conv_post.sv
// tb_conv_post: directed vector table plus backpressure, random-traffic and mid-stream
// reset sequences for conv_post with LANES=4, SHIFT=4, OUT_W=16, FIFO_DEPTH=8.
module tb_conv_post;
    localparam int L = 4;
    typedef logic [L-1:0][31:0] vec_t;
    typedef logic [L-1:0][15:0] ovec_t;
    typedef struct {
        vec_t        d;
        logic [31:0] b;
        ovec_t       e;
    } vrec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_post_if #(.LANES(L), .OUT_W(16)) bus();
    conv_post #(.LANES(L), .SHIFT(4), .OUT_W(16), .FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks, errors, cyc, nid, rx, r0, t_push, last_rise, maxc, froze;
    int    src [L];
    bit    hv [L][L-1];
    vec_t  vd [256];
    vec_t  pend [$];
    ovec_t exp_q [$];
    bit    hold_p, prev_ov, use_tbl;
    ovec_t hold_d, next_e;
    vrec_t tbl [6];
    vec_t  v;

    function automatic logic [15:0] ref1(logic [31:0] d, logic [31:0] b);
        logic signed [31:0] s;
        s = $signed(d + b);
        if (s < 0) return 16'h0;
        if (s >= 32'sh80000) return 16'h7FFF;
        return s[19:4];
    endfunction

    function automatic ovec_t model(vec_t d, vec_t b);
        ovec_t o;
        for (int j = 0; j < L; j++) o[j] = ref1(d[j], b[j]);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int j = 0; j < L; j++) begin
            bus.conv_valid[j] = (src[j] >= 0);
            bus.conv_data[j]  = (src[j] >= 0) ? vd[src[j] % 256][j] : 32'h0;
        end
    endtask

    task automatic clear_bench();
        for (int j = 0; j < L; j++) begin
            src[j] = -1;
            for (int k = 0; k < L - 1; k++) hv[j][k] = 1'b0;
        end
        exp_q.delete();
        pend.delete();
        hold_p  = 1'b0;
        prev_ov = 1'b0;
        drive();
    endtask

    task automatic monitor();
        bit al0, al_ok;
        if (rst) return;
        al0   = hv[0][L-2];
        al_ok = 1'b1;
        for (int j = 1; j < L; j++)
            if (((j == L - 1) ? bus.conv_valid[j] : hv[j][L-2-j]) != al0) al_ok = 1'b0;
        chk("lane_align", al_ok, 1);
        chk("stall_rule", bus.conv_stall, dut.w_count >= 4);
        chk("no_overflow", dut.w_wr && dut.w_count == 8 && !dut.w_rd, 0);
        if (int'(dut.w_count) > maxc) maxc = int'(dut.w_count);
        if (hold_p) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, hold_d);
        end
        if (bus.out_valid && !prev_ov) last_rise = cyc;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", bus.out_data, 64'hX);
            else chk("out_data", bus.out_data, exp_q.pop_front());
            rx++;
        end
        hold_p  = bus.out_valid && !bus.out_ready;
        hold_d  = bus.out_data;
        prev_ov = bus.out_valid;
    endtask

    // One clock: check outputs at negedge, then model the array advancing after posedge.
    task automatic step(input bit gap, input bit rdy);
        bit a;
        @(negedge clk);
        monitor();
        a = !(bus.conv_stall && |bus.conv_valid);
        if (!a) froze++;
        @(posedge clk);
        cyc++;
        #1;
        if (a && !rst) begin
            for (int j = 0; j < L - 1; j++) begin
                for (int k = L - 2; k > 0; k--) hv[j][k] = hv[j][k-1];
                hv[j][0] = bus.conv_valid[j];
            end
            for (int j = L - 1; j > 0; j--) src[j] = src[j-1];
            if (!gap && pend.size() > 0) begin
                vd[nid % 256] = pend.pop_front();
                src[0] = nid;
                exp_q.push_back(use_tbl ? next_e : model(vd[nid % 256], bus.bias));
                t_push = cyc;
                nid++;
            end else begin
                src[0] = -1;
            end
        end
        bus.out_ready = rdy;
        drive();
    endtask

    initial begin
        bus.bias      = '0;
        bus.out_ready = 1'b1;
        clear_bench();
        repeat (3) step(1, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_conv_stall", bus.conv_stall, 0);
        chk("reset_out_data", bus.out_data, 0);
        rst = 1'b0;
        repeat (2) step(1, 1);

        tbl[0] = '{{32'd64, 32'd48, 32'd32, 32'd16}, 32'd0, {16'd4, 16'd3, 16'd2, 16'd1}};
        tbl[1] = '{{4{32'hFFFFFF9C}}, 32'd50, {4{16'd0}}};
        tbl[2] = '{{4{32'd30}}, 32'd50, {4{16'd5}}};
        tbl[3] = '{{4{32'h7FFF0000}}, 32'd0, {4{16'h7FFF}}};
        tbl[4] = '{{4{32'h7FFFFFFF}}, 32'd1, {4{16'd0}}};
        tbl[5] = '{{32'h80000, 32'h7FFF0, 32'd15, 32'hFFFFFFFF}, 32'd0,
                   {16'h7FFF, 16'h7FFF, 16'd0, 16'd0}};
        use_tbl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.bias = {L{tbl[i].b}};
            next_e   = tbl[i].e;
            pend.push_back(tbl[i].d);
            r0 = rx;
            step(0, 1);
            for (int k = 0; k < 20 && rx == r0; k++) step(1, 1);
            chk($sformatf("tbl%0d_beat", i), rx - r0, 1);
            chk($sformatf("tbl%0d_latency", i), last_rise - t_push, 5);
            repeat (3) step(1, 1);
            chk($sformatf("tbl%0d_one_beat", i), rx - r0, 1);
            chk($sformatf("tbl%0d_idle", i), bus.out_valid, 0);
        end
        use_tbl  = 1'b0;
        bus.bias = '0;

        // Backpressure: the array freezes at count 4 with vector 9 still upstream.
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < L; j++) v[j] = 32'((i * 16 + j) << 4);
            pend.push_back(v);
        end
        froze = 0;
        maxc  = 0;
        r0    = rx;
        repeat (30) step(0, 0);
        chk("bp_count_hold", dut.w_count, 4);
        chk("bp_stall", bus.conv_stall, 1);
        chk("bp_frozen", froze > 0, 1);
        chk("bp_pending", pend.size(), 1);
        chk("bp_max_count", maxc <= 8, 1);
        for (int k = 0; k < 200 && rx < r0 + 10; k++) step(0, 1);
        chk("bp_all_out", rx - r0, 10);

        // Random bubbles, 30% ready, per-lane bias.
        bus.bias = {32'd256, 32'd2000, 32'd0, 32'hFFFFFC18};
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < L; j++)
                case ($urandom_range(0, 3))
                    0: v[j] = $urandom;
                    1: v[j] = 32'h7FFF0000 + 32'($urandom_range(0, 65535));
                    default: v[j] = 32'($urandom_range(0, 600000)) - 32'd100000;
                endcase
            pend.push_back(v);
        end
        r0 = rx;
        for (int k = 0; k < 3000 && rx < r0 + 40; k++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) < 3);
        chk("rand_all_out", rx - r0, 40);
        chk("rand_queue_empty", exp_q.size(), 0);
        repeat (3) step(1, 1);
        bus.bias = '0;

        // Mid-stream asynchronous reset with five entries buffered.
        for (int i = 0; i < 5; i++) pend.push_back({4{32'(i * 256)}});
        for (int k = 0; k < 40 && dut.w_count != 5; k++) step(0, 0);
        repeat (2) step(1, 0);
        chk("rst_pre_count", dut.w_count, 5);
        chk("rst_pre_stall", bus.conv_stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.out_valid, 0);
        chk("rst_async_stall", bus.conv_stall, 0);
        chk("rst_async_data", bus.out_data, 0);
        clear_bench();
        repeat (2) step(1, 0);
        rst = 1'b0;
        repeat (2) step(1, 1);
        use_tbl = 1'b1;
        next_e  = {16'd40, 16'd30, 16'd20, 16'd10};
        pend.push_back({32'd640, 32'd480, 32'd320, 32'd160});
        r0 = rx;
        step(0, 1);
        for (int k = 0; k < 20 && rx == r0; k++) step(1, 1);
        chk("post_rst_beat", rx - r0, 1);
        chk("post_rst_latency", last_rise - t_push, 5);
        repeat (4) step(1, 1);
        chk("post_rst_no_stale", rx - r0, 1);
        chk("post_rst_idle", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
